div_arbiter: RTL
================

# div_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle signed 16-bit divider among `NREQ` requesters. Each requester uses a four-phase REQ/ACK handshake. The block grants one requester at a time and latches that requester's operands. It then runs an unsigned restoring division at one quotient bit per cycle, applies sign correction, and holds the result on a shared result bus until the requester releases REQ. It sits between the per-lane request logic and the single shared division datapath.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 16: operand width. Fixed at 16 for this release.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `REQ`  in  NREQ  per-requester request level.
- `A`  in  NREQ*16  packed signed dividends; lane i is `A[16*i +: 16]`.
- `D`  in  NREQ*16  packed signed divisors; same packing as `A`.
- `ACK`  out  NREQ  one-hot acknowledge; result valid while high.
- `Q`  out  16  signed quotient, shared bus.
- `R`  out  16  signed remainder, shared bus.
- `FDBZ`  out  1  divide-by-zero flag for the current result.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: arbitrate among requesters.
  - DIV: 16 iterations, counter 15 down to 0.
  - FIX: sign correction and output registration.
  - DONE: hold the result until the granted requester drops REQ.
- Arbitration in IDLE:
  - Round-robin pointer `ptr`. The first i with REQ[i]=1, searching ptr, ptr+1, …, wrapping modulo NREQ, is granted.
  - On the grant edge, capture g=i, |A_g|, |D_g|, sign(A_g), and sign(A_g)^sign(D_g).
- Grant transitions:
  - If D_g = 0, go to FIX with the zero flag set.
  - Otherwise go to DIV.
- Magnitudes are 16-bit unsigned. |0x8000| = 0x8000.
- DIV step, once per cycle:
  - rem = {rem[14:0], dividend msb}; shift dividend left.
  - If rem ≥ |D|, then rem -= |D| and the quotient bit is 1.
  - After 16 steps go to FIX.
- FIX:
  - Q = quotient negated if signs differ; R = rem negated if A<0. Both are truncated toward zero, and the sign of R follows A.
  - Wrap rule: -32768 / -1 gives Q=0x8000, R=0. No overflow flag.
  - Divide by zero: Q = 0x7FFF if A_g ≥ 0, else 0x8000. R = 0. FDBZ = 1.
  - For all other results FDBZ = 0.
  - Register Q, R, FDBZ and set ACK[g]. Go to DONE.
- DONE:
  - ACK[g], Q, R and FDBZ are held.
  - On the first edge where REQ[g]=0: clear ACK, set ptr = (g+1) mod NREQ, go to IDLE.
- Q, R and FDBZ keep their last value after ACK falls.
- Operands are sampled only on the grant edge. Changes to A or D after grant are ignored.
- If the requester drops REQ before ACK, the operation still completes. ACK then pulses for exactly one cycle. This is a protocol violation, but the behaviour is defined.

## Timing
- Reset values: ACK=0, Q=0, R=0, FDBZ=0, BUSY=0. State=IDLE, ptr=0, datapath registers 0. Reset takes effect immediately, including mid-DIV or in DONE. Any in-flight operation is dropped with no ACK.
- Normal division latency: the edge that samples REQ in IDLE is edge 0. ACK[g] is high after edge 17 (16 DIV edges plus FIX).
- Divide-by-zero latency: ACK is high after edge 1.
- ACK falls one edge after REQ[g]=0 is sampled.
- IDLE lasts at least one cycle between grants. Minimum back-to-back service period is 19 cycles.
- REQ from other requesters asserted during service is held pending and served in rotation. No requester waits more than NREQ-1 services.

## Structure
- Package `div_pkg`:
  - `DIV_W=16`.
  - `Q_POS_SAT=16'h7FFF`, `Q_NEG_SAT=16'h8000`.
  - State enum `div_state_t` {IDLE, DIV, FIX, DONE}.
- Sub-module `udiv_iter`: unsigned restoring core holding the rem, dividend-shift and quotient registers plus the 4-bit step counter. It has inputs load/step and outputs done/quo/rem.
- `div_arbiter` contains the FSM, the round-robin pointer and sign handling.

## Test plan
- Single requester: REQ[0] with A=100, D=7 gives ACK[0] after edge 17, Q=14, R=2, FDBZ=0.
- Sign cases:
  - A=-100, D=7 gives Q=0xFFF2, R=0xFFFE.
  - A=100, D=-7 gives Q=0xFFF2, R=2.
  - A=-100, D=-7 gives Q=14, R=0xFFFE.
- Divide by zero:
  - A=5, D=0 gives ACK after edge 1, Q=0x7FFF, R=0, FDBZ=1.
  - A=-5, D=0 gives Q=0x8000.
- Extremes:
  - -32768 / -1 gives Q=0x8000, R=0.
  - -32768 / 3 gives Q=0xD556, R=0xFFFE.
  - 0x7FFF / 0x8000 gives Q=0, R=0x7FFF.
- Arbitration: all four REQ asserted at once are served in order 0,1,2,3. Re-asserting REQ[0] during service of lane 1 means lane 0 is served after lane 3.
- Reset and early drop:
  - RST pulsed mid-DIV (edge 8) gives all outputs 0 immediately and no ACK.
  - After reset, REQ[2] alone is served normally.
  - Dropping REQ early gives a one-cycle ACK pulse.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants, FSM state type and magnitude helper for the shared divider.
package div_pkg;

    localparam int          DIV_W     = 16;
    localparam logic [15:0] Q_POS_SAT = 16'h7FFF;
    localparam logic [15:0] Q_NEG_SAT = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // |0x8000| stays 0x8000, which the unsigned core handles correctly.
    function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] x);
        return x[DIV_W-1] ? (~x + 16'd1) : x;
    endfunction

endpackage

// File: rtl/udiv_iter.sv
// Unsigned restoring divider core: one quotient bit per step, 16 steps per load.
module udiv_iter
    import div_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             done_o,
    output logic [DIV_W-1:0] quo_o,
    output logic [DIV_W-1:0] rem_o
);

    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] dvd_q, dvd_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [DIV_W:0]   trial;
    logic [DIV_W:0]   diff;

    // Partial remainder is kept below the divisor, so 17 bits hold the shifted value.
    assign trial = {rem_q, dvd_q[DIV_W-1]};
    assign diff  = trial - {1'b0, dvs_q};

    always_comb begin
        rem_d = rem_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        if (load_i) begin
            rem_d = '0;
            dvd_d = dividend_i;
            dvs_d = divisor_i;
            quo_d = '0;
            cnt_d = 4'd15;
        end else if (step_i) begin
            dvd_d = {dvd_q[DIV_W-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = diff[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b0};
            end
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 4'd0);
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one signed 16-bit iterative divider among NREQ requesters.
// Handshake: REQ[i] rises with operands valid; ACK[i] rises with Q/R/FDBZ valid; ACK falls one edge after REQ[i] is seen low.
module div_arbiter
    import div_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = DIV_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ*W-1:0] A,
    input  logic [NREQ*W-1:0] D,
    output logic [NREQ-1:0] ACK,
    output logic [W-1:0]    Q,
    output logic [W-1:0]    R,
    output logic            FDBZ,
    output logic            BUSY,
    output div_state_t      DBG_STATE
);

    localparam int             IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0]    NREQ_W = (IW+1)'(NREQ);
    localparam logic [IW-1:0]  LAST   = IW'(NREQ - 1);

    div_state_t       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic             neg_q, neg_d;
    logic             sa_q, sa_d;
    logic             dbz_q, dbz_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     r_q, r_d;
    logic             fdbz_q, fdbz_d;

    logic [W-1:0]     a_lane [NREQ];
    logic [W-1:0]     d_lane [NREQ];
    logic             found;
    logic [IW-1:0]    pick;
    logic [IW:0]      sum;
    logic             load, step, core_done;
    logic [W-1:0]     core_quo, core_rem;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign a_lane[i] = A[i*W +: W];
        assign d_lane[i] = D[i*W +: W];
    end

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (REQ[sum[IW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        dbz_d   = dbz_q;
        ack_d   = ack_q;
        q_d     = q_q;
        r_d     = r_q;
        fdbz_d  = fdbz_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    sa_d    = a_lane[pick][W-1];
                    neg_d   = a_lane[pick][W-1] ^ d_lane[pick][W-1];
                    dbz_d   = (d_lane[pick] == '0);
                    load    = 1'b1;
                    state_d = (d_lane[pick] == '0) ? FIX : DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (core_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dbz_q) begin
                    q_d    = sa_q ? Q_NEG_SAT : Q_POS_SAT;
                    r_d    = '0;
                    fdbz_d = 1'b1;
                end else begin
                    q_d    = neg_q ? (~core_quo + 16'd1) : core_quo;
                    r_d    = sa_q ? (~core_rem + 16'd1) : core_rem;
                    fdbz_d = 1'b0;
                end
                ack_d        = '0;
                ack_d[gnt_q] = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (!REQ[gnt_q]) begin
                    ack_d   = '0;
                    ptr_d   = (gnt_q == LAST) ? '0 : gnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            dbz_q   <= 1'b0;
            ack_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            fdbz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            dbz_q   <= dbz_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            r_q     <= r_d;
            fdbz_q  <= fdbz_d;
        end
    end

    udiv_iter u_core (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (load),
        .step_i     (step),
        .dividend_i (mag(a_lane[pick])),
        .divisor_i  (mag(d_lane[pick])),
        .done_o     (core_done),
        .quo_o      (core_quo),
        .rem_o      (core_rem)
    );

    assign ACK       = ack_q;
    assign Q         = q_q;
    assign R         = r_q;
    assign FDBZ      = fdbz_q;
    assign BUSY      = (state_q != IDLE);
    assign DBG_STATE = state_q;

endmodule
